ok_multi_pipe_readout: RTL and testbench

Parametrised N-channel readout engine that sits between the measurement datapaths and one Opal Kelly block-throttled pipe-out endpoint in the host interface. Each channel streams 32-bit words into its own FIFO. The engine packs those words into fixed-length frames, each one a header followed by data from a single channel, and picks the next channel round-robin. It also provides per-channel overflow flags and an XEM7310-style open-drain LED status.

---
 rtl/ok_multi_pipe_readout.sv | 198 +++++++++++++++++++
 tb/tb_ok_multi_pipe_readout.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ok_multi_pipe_readout.sv
// Purpose: N-channel readout engine packing per-channel FIFO words into fixed BLOCK-word frames for a throttled pipe-out.
// Latency: a channel reaching BLOCK-1 words arms ep_ready/header one edge after its count update; each ep_read advances ep_datain on that edge.
// Backpressure: ch_ready drops when a channel FIFO is full (words pushed then are dropped and flagged); ep_read outside a frame is ignored and flagged.
// Ports: okClk/rst (sync, active-high); ch_valid/ch_data/ch_ready per channel input; ep_read/ep_ready/ep_datain pipe-out side;
//        overflow/underrun sticky status; led open-drain overflow indicators (bit i low when overflow[i]).

module ok_multi_pipe_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      // simultaneous push and pop leaves the count unchanged
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == ($clog2(DEPTH) + 1)'(DEPTH));
endmodule

module ok_multi_pipe_readout #(
  parameter int NCH   = 4,
  parameter int DEPTH = 64,
  parameter int BLOCK = 16
) (
  input  logic              okClk,
  input  logic              rst,
  input  logic [NCH-1:0]    ch_valid,
  input  logic [32*NCH-1:0] ch_data,
  output logic [NCH-1:0]    ch_ready,
  input  logic              ep_read,
  output logic              ep_ready,
  output logic [31:0]       ep_datain,
  output logic [NCH-1:0]    overflow,
  output logic              underrun,
  output logic [7:0]        led
);
  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ELIG    = CW'(BLOCK - 1);
  localparam logic [8:0]    LAST_DW = 9'(BLOCK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]     state;
  logic [2:0]     cur;
  logic [2:0]     last;
  logic [8:0]     dcnt;     // index of the data word currently on ep_datain
  logic [15:0]    seq [NCH];

  logic [31:0]    head [NCH];
  logic [CW-1:0]  cnt  [NCH];
  logic [NCH-1:0] full;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic [NCH-1:0] elig;

  logic           frame_pop;
  logic           frame_end;
  logic [31:0]    head_sel;
  logic [2:0]     win;
  logic [15:0]    win_seq;

  // The final read of a frame only retires the last word already on ep_datain,
  // so it must not pop; every earlier read pulls the next word forward.
  assign frame_pop = ep_read && ((state == S_HDR) || (state == S_DATA && dcnt != LAST_DW));
  assign frame_end = ep_read && (state == S_DATA) && (dcnt == LAST_DW);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign push[i]     = ch_valid[i] && !full[i];
    assign ch_ready[i] = !full[i];
    assign elig[i]     = (cnt[i] >= ELIG);
    assign pop[i]      = frame_pop && (cur == 3'(i));

    ok_multi_pipe_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (okClk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (ch_data[32*i +: 32]),
      .rdata (head[i]),
      .count (cnt[i]),
      .full  (full[i])
    );
  end

  // Round-robin: pick the eligible channel at the smallest distance past `last`.
  always_comb begin
    int best;
    int d;
    head_sel = '0;
    win      = '0;
    win_seq  = '0;
    best     = NCH;
    d        = 0;
    for (int j = 0; j < NCH; j++) begin
      if (cur == 3'(j)) head_sel = head[j];
      d = (j - int'(last) - 1 + 2 * NCH) % NCH;
      if (elig[j] && d < best) begin
        best    = d;
        win     = 3'(j);
        win_seq = seq[j];
      end
    end
  end

  always_ff @(posedge okClk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) seq[i] <= '0;
    end else if (frame_end) begin
      for (int i = 0; i < NCH; i++)
        if (cur == 3'(i)) seq[i] <= seq[i] + 16'd1;
    end
  end

  always_ff @(posedge okClk) begin
    if (rst) begin
      state     <= S_IDLE;
      cur       <= '0;
      last      <= 3'(NCH - 1);
      dcnt      <= '0;
      ep_ready  <= 1'b0;
      ep_datain <= '0;
      overflow  <= '0;
      underrun  <= 1'b0;
    end else begin
      overflow <= overflow | (ch_valid & ~ch_ready);
      case (state)
        S_IDLE: begin
          if (ep_read) underrun <= 1'b1;
          if (|elig) begin
            state     <= S_HDR;
            cur       <= win;
            ep_ready  <= 1'b1;
            ep_datain <= {8'hA5, 5'd0, win, win_seq};
          end
        end
        S_HDR: begin
          if (ep_read) begin
            state     <= S_DATA;
            ep_ready  <= 1'b0;
            ep_datain <= head_sel;
            dcnt      <= 9'd1;
          end
        end
        S_DATA: begin
          if (frame_end) begin
            state     <= S_IDLE;
            ep_datain <= '0;
            last      <= cur;
          end else if (ep_read) begin
            ep_datain <= head_sel;
            dcnt      <= dcnt + 9'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_led
    if (i < NCH) begin : g_used
      assign led[i] = overflow[i] ? 1'b0 : 1'bz;
    end else begin : g_unused
      assign led[i] = 1'bz;
    end
  end
endmodule

// File: tb/tb_ok_multi_pipe_readout.sv
// Purpose: self-checking bench for ok_multi_pipe_readout (NCH=4, DEPTH=64, BLOCK=16).
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled at that same point after the edge.
// Backpressure: frames are read with optional gaps and concurrent pushes; every header wait is bounded.

module tb_ok_multi_pipe_readout;
  localparam int NCH   = 4;
  localparam int DEPTH = 64;
  localparam int BLOCK = 16;

  logic              okClk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    ch_valid;
  logic [32*NCH-1:0] ch_data;
  logic [NCH-1:0]    ch_ready;
  logic              ep_read;
  logic              ep_ready;
  logic [31:0]       ep_datain;
  logic [NCH-1:0]    overflow;
  logic              underrun;
  logic [7:0]        led;

  ok_multi_pipe_readout #(.NCH(NCH), .DEPTH(DEPTH), .BLOCK(BLOCK)) dut (
    .okClk     (okClk),
    .rst       (rst),
    .ch_valid  (ch_valid),
    .ch_data   (ch_data),
    .ch_ready  (ch_ready),
    .ep_read   (ep_read),
    .ep_ready  (ep_ready),
    .ep_datain (ep_datain),
    .overflow  (overflow),
    .underrun  (underrun),
    .led       (led)
  );

  always #5 okClk = ~okClk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        rd;
    logic        exp_rdy;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge okClk);
    #1;
  endtask

  function automatic logic [31:0] dword(input int ch, input int idx);
    return {4'hC, 4'(ch), 8'h00, 16'(idx)};
  endfunction

  function automatic logic [31:0] hdr(input int ch, input int sq);
    return {8'hA5, 5'd0, 3'(ch), 16'(sq)};
  endfunction

  task automatic push_multi(input logic [3:0] mask, input int first, input int n);
    for (int k = 0; k < n; k++) begin
      ch_valid = mask;
      for (int c = 0; c < NCH; c++) ch_data[32*c +: 32] = dword(c, first + k);
      step();
    end
    ch_valid = '0;
  endtask

  task automatic push_words(input int ch, input int first, input int n);
    logic [3:0] m;
    m = '0;
    m[ch] = 1'b1;
    push_multi(m, first, n);
  endtask

  task automatic wait_hdr(input int ch, input int sq);
    int n;
    n = 0;
    while (ep_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("hdr_ready", 32'(ep_ready), 32'd1);
    chk("hdr_word", ep_datain, hdr(ch, sq));
  endtask

  // Reads one complete frame; optional idle gap after each read and optional
  // push into the same channel concurrent with reads 2..BLOCK.
  task automatic read_frame(input int ch, input int sq, input int first, input int gap,
                            input bit pushing, input int push_first);
    wait_hdr(ch, sq);
    for (int k = 1; k <= BLOCK; k++) begin
      ep_read = 1'b1;
      if (pushing && k >= 2) begin
        ch_valid[ch] = 1'b1;
        ch_data[32*ch +: 32] = dword(ch, push_first + k - 2);
      end
      step();
      ep_read  = 1'b0;
      ch_valid = '0;
      if (k < BLOCK) begin
        chk("frame_data", ep_datain, dword(ch, first + k - 1));
        if (k == 1) chk("ready_drop", 32'(ep_ready), 32'd0);
        if (gap > 0) begin
          repeat (gap) step();
          chk("gap_hold", ep_datain, dword(ch, first + k - 1));
        end
      end else begin
        chk("frame_end_dat", ep_datain, 32'd0);
        chk("frame_end_rdy", 32'(ep_ready), 32'd0);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  initial begin
    vec_t v;
    rst      = 1'b1;
    ch_valid = '0;
    ch_data  = '0;
    ep_read  = 1'b0;
    repeat (3) step();

    // reset state
    chk("rst_ready", 32'(ep_ready), 32'd0);
    chk("rst_dat", ep_datain, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unr", 32'(underrun), 32'd0);
    chk("rst_chrdy", 32'(ch_ready), 32'hF);
    rst = 1'b0;

    // table: two back-to-back frames on ch1
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 15; k++) begin
        v = '{valid: 4'b0010, data: dword(1, 15*f + k), rd: 1'b0, exp_rdy: 1'b0, exp_dat: 32'd0};
        tbl.push_back(v);
      end
      v = '{valid: 4'b0000, data: 32'd0, rd: 1'b0, exp_rdy: 1'b1, exp_dat: hdr(1, f)};
      tbl.push_back(v);
      for (int k = 1; k <= 16; k++) begin
        v = '{valid: 4'b0000, data: 32'd0, rd: 1'b1, exp_rdy: 1'b0,
              exp_dat: (k < 16) ? dword(1, 15*f + k - 1) : 32'd0};
        tbl.push_back(v);
      end
    end
    foreach (tbl[i]) begin
      ch_valid = tbl[i].valid;
      ch_data  = {4{tbl[i].data}};
      ep_read  = tbl[i].rd;
      step();
      ch_valid = '0;
      ep_read  = 1'b0;
      chk("vec_rdy", 32'(ep_ready), 32'(tbl[i].exp_rdy));
      chk("vec_dat", ep_datain, tbl[i].exp_dat);
    end

    // underrun in IDLE, then a paced frame on ch3
    push_words(3, 0, 14);
    ep_read = 1'b1;
    step();
    ep_read = 1'b0;
    chk("unr_flag", 32'(underrun), 32'd1);
    chk("unr_dat", ep_datain, 32'd0);
    chk("unr_rdy", 32'(ep_ready), 32'd0);
    push_words(3, 14, 1);
    read_frame(3, 0, 0, 5, 1'b0, 0);

    // reset mid-frame on ch1 (third frame, seq 2)
    push_words(1, 30, 20);
    wait_hdr(1, 2);
    for (int k = 1; k <= 8; k++) begin
      ep_read = 1'b1;
      step();
      ep_read = 1'b0;
      chk("mid_data", ep_datain, dword(1, 30 + k - 1));
    end
    rst = 1'b1;
    step();
    chk("mid_rst_rdy", 32'(ep_ready), 32'd0);
    chk("mid_rst_dat", ep_datain, 32'd0);
    chk("mid_rst_unr", 32'(underrun), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_chrdy", 32'(ch_ready), 32'hF);
    rst = 1'b0;
    repeat (3) step();
    chk("mid_idle_rdy", 32'(ep_ready), 32'd0);
    push_words(1, 200, 15);
    read_frame(1, 0, 200, 0, 1'b0, 0);

    // round-robin
    do_reset();
    push_multi(4'b1101, 0, 15);
    read_frame(0, 0, 0, 0, 1'b0, 0);
    push_multi(4'b1001, 15, 15);
    read_frame(2, 0, 0, 0, 1'b0, 0);
    read_frame(3, 0, 0, 0, 1'b0, 0);
    read_frame(0, 1, 15, 0, 1'b0, 0);
    read_frame(3, 1, 15, 0, 1'b0, 0);

    // overflow on ch2
    do_reset();
    for (int k = 0; k < 70; k++) begin
      ch_valid = 4'b0100;
      ch_data[64 +: 32] = (k < 64) ? dword(2, k) : (32'hDEAD_0000 + 32'(k));
      step();
      ch_valid = '0;
      if (k == 63) begin
        chk("ovf_full_rdy", 32'(ch_ready[2]), 32'd0);
        chk("ovf_not_yet", 32'(overflow), 32'd0);
      end
    end
    chk("ovf_flag", 32'(overflow), 32'h4);
    chk("ovf_led", 32'(led[2]), 32'd0);
    chk("ovf_chrdy", 32'(ch_ready), 32'hB);
    for (int s = 0; s < 4; s++) read_frame(2, s, 15*s, 0, 1'b0, 0);
    push_words(2, 64, 11);
    read_frame(2, 4, 60, 0, 1'b0, 0);

    // simultaneous push and pop on a full ch0
    do_reset();
    push_words(0, 0, 64);
    chk("sim_full", 32'(ch_ready[0]), 32'd0);
    read_frame(0, 0, 0, 0, 1'b1, 64);
    chk("sim_no_drop", 32'(overflow), 32'd0);
    for (int s = 1; s < 5; s++) read_frame(0, s, 15*s, 0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
